// File: rtl/hazard_pkg.sv
// Shared types for the destination hazard tracker: forwarding-select
// encodings, the per-stage slot record and the saturating Tnew decrement.
package hazard_pkg;

    localparam int SLOT_ADDR_W = 5;
    localparam int SLOT_T_W    = 2;

    localparam logic [1:0] FWD_NONE = 2'b00;
    localparam logic [1:0] FWD_E    = 2'b01;
    localparam logic [1:0] FWD_M    = 2'b10;
    localparam logic [1:0] FWD_W    = 2'b11;

    typedef struct packed {
        logic [SLOT_ADDR_W-1:0] addr;
        logic [SLOT_T_W-1:0]    tnew;
    } slot_t;

    // An empty stage: writes nothing, nothing pending.
    localparam slot_t BUBBLE = '{addr: '0, tnew: '0};

    // Count down toward "result ready", holding at zero instead of wrapping.
    function automatic logic [SLOT_T_W-1:0] sat_dec(input logic [SLOT_T_W-1:0] t);
        return (t == '0) ? '0 : t - SLOT_T_W'(1);
    endfunction

endpackage

// File: rtl/hazard_slot.sv
// One pipeline slot {addr, tnew}. Loads its input or a bubble each cycle;
// DEC_EN makes the captured tnew one cycle closer to ready.
module hazard_slot
    import hazard_pkg::*;
#(
    parameter bit DEC_EN = 1'b1
) (
    input  logic  clk,
    input  logic  rst_n,
    input  logic  load,
    input  slot_t d,
    output slot_t q
);

    // Slot register: bubble on reset or when load is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= BUBBLE;
        end else if (load) begin
            q.addr <= d.addr;
            q.tnew <= DEC_EN ? sat_dec(d.tnew) : d.tnew;
        end else begin
            q <= BUBBLE;
        end
    end

endmodule

// File: rtl/dest_hazard_tracker.sv
// Tracks the destination register and Tnew of the instructions in E/M/W and
// produces the D-stage stall request plus rs/rt bypass selects.
// Optional feature: define DEST_HAZARD_FWD_W_EN to let a W-stage match
// forward (select 11); otherwise the register file is expected to provide
// write-before-read bypass and W is tracked but never selected.
// ADDR_W/T_W must agree with the slot widths in hazard_pkg.
module dest_hazard_tracker
    import hazard_pkg::*;
#(
    parameter int ADDR_W = SLOT_ADDR_W,
    parameter int T_W    = SLOT_T_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] D_WAddr,
    input  logic [T_W-1:0]    D_Tnew,
    input  logic [ADDR_W-1:0] D_Rs,
    input  logic [ADDR_W-1:0] D_Rt,
    input  logic              D_UseRs,
    input  logic              D_UseRt,
    input  logic [T_W-1:0]    D_TuseRs,
    input  logic [T_W-1:0]    D_TuseRt,
    input  logic              Flush_E,
    output logic              Stall,
    output logic [1:0]        FwdRs,
    output logic [1:0]        FwdRt
);

`ifdef DEST_HAZARD_FWD_W_EN
    localparam bit FWD_W_EN = 1'b1;
`else
    localparam bit FWD_W_EN = 1'b0;
`endif

    slot_t d_slot, e_slot, m_slot, w_slot;
    logic  e_load;
    logic  stall_rs, stall_rt;
    logic  unused_w_tnew;

    assign d_slot = '{addr: D_WAddr, tnew: D_Tnew};

    // Stall and flush both just turn the E load into a bubble, so asserting
    // them together has no extra effect.
    assign e_load = !(Stall || Flush_E);

    // The W slot's remaining Tnew never influences a decision.
    assign unused_w_tnew = ^w_slot.tnew;

    // E takes D's raw Tnew (measured from E entry); M and W count it down.
    hazard_slot #(.DEC_EN(1'b0)) u_slot_e (
        .clk(clk), .rst_n(rst_n), .load(e_load), .d(d_slot), .q(e_slot)
    );
    hazard_slot #(.DEC_EN(1'b1)) u_slot_m (
        .clk(clk), .rst_n(rst_n), .load(1'b1), .d(e_slot), .q(m_slot)
    );
    hazard_slot #(.DEC_EN(1'b1)) u_slot_w (
        .clk(clk), .rst_n(rst_n), .load(1'b1), .d(m_slot), .q(w_slot)
    );

    // A read stalls when a producer in E or M will not be ready by the time
    // the operand is needed. $0 is never a real dependency.
    function automatic logic need_stall(input logic              use_r,
                                        input logic [ADDR_W-1:0] r,
                                        input logic [T_W-1:0]    tuse,
                                        input slot_t             e,
                                        input slot_t             m);
        logic hit_e, hit_m;
        hit_e = use_r && (r != '0) && (e.addr == r);
        hit_m = use_r && (r != '0) && (m.addr == r);
        return (hit_e && (e.tnew > tuse)) || (hit_m && (m.tnew > tuse));
    endfunction

    // Nearest producer wins; a nearer producer that is not ready yet masks
    // older copies so a stale value is never selected.
    function automatic logic [1:0] fwd_sel(input logic [ADDR_W-1:0] r,
                                           input slot_t             e,
                                           input slot_t             m,
                                           input slot_t             w);
        if (r == '0)
            return FWD_NONE;
        else if (e.addr == r)
            return (e.tnew == '0) ? FWD_E : FWD_NONE;
        else if (m.addr == r)
            return (m.tnew == '0) ? FWD_M : FWD_NONE;
        else if (FWD_W_EN && (w.addr == r))
            return FWD_W;
        else
            return FWD_NONE;
    endfunction

    // Same-cycle hazard detection and bypass selection from state + D inputs.
    always_comb begin
        stall_rs = need_stall(D_UseRs, D_Rs, D_TuseRs, e_slot, m_slot);
        stall_rt = need_stall(D_UseRt, D_Rt, D_TuseRt, e_slot, m_slot);
        Stall    = stall_rs || stall_rt;
        FwdRs    = fwd_sel(D_Rs, e_slot, m_slot, w_slot);
        FwdRt    = fwd_sel(D_Rt, e_slot, m_slot, w_slot);
    end

endmodule
